// File: rtl/seg_scan_driver.sv
// Multiplexed 4-digit 7-segment scan driver with per-frame snapshot, leading-zero blanking and dead time.
// Latency: digits/dp_mask take effect at the next frame start (DEAD-to-ON into digit 0); outputs decode from registers.
// Backpressure: none; free-running scan, enable only darkens the outputs.
module seg_scan_driver #(
  parameter int DIV  = 1000,
  parameter int DEAD = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_mask,
  input  logic        lz_en,
  input  logic        enable,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  typedef enum logic {ST_ON, ST_DEAD} state_t;

  state_t      r_state;
  logic [1:0]  r_idx;
  logic [15:0] r_on_cnt;
  logic [7:0]  r_dead_cnt;
  logic [15:0] r_snap_digits;
  logic [3:0]  r_snap_dp;
  logic        r_frame_done;

  logic [3:0]  w_digit;
  logic [3:0]  w_upper_zero;
  logic        w_blank;
  logic [6:0]  w_seg_code;

  // Scan sequencer: ON/DEAD timing, digit index advance and frame snapshot capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_DEAD;
      r_idx         <= 2'd3;
      r_on_cnt      <= '0;
      r_dead_cnt    <= '0;
      r_snap_digits <= '0;
      r_snap_dp     <= '0;
      r_frame_done  <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        ST_ON: begin
          if (r_on_cnt == 16'(DIV - 1)) begin
            r_on_cnt <= '0;
            r_state  <= ST_DEAD;
          end else begin
            r_on_cnt <= r_on_cnt + 16'd1;
          end
        end
        default: begin
          if (r_dead_cnt == 8'(DEAD - 1)) begin
            r_dead_cnt <= '0;
            r_idx      <= r_idx + 2'd1;
            r_state    <= ST_ON;
            // Wrapping back to digit 0 starts a new frame: freeze inputs for its duration.
            if (r_idx == 2'd3) begin
              r_snap_digits <= digits;
              r_snap_dp     <= dp_mask;
              r_frame_done  <= 1'b1;
            end
          end else begin
            r_dead_cnt <= r_dead_cnt + 8'd1;
          end
        end
      endcase
    end
  end

  assign frame_done = r_frame_done;
  assign w_digit    = r_snap_digits[{r_idx, 2'b00} +: 4];

  // Leading-zero chain: bit i set when snapshot digits 3..i are all zero; digit 0 never blanks.
  always_comb begin
    w_upper_zero    = 4'b0000;
    w_upper_zero[3] = (r_snap_digits[15:12] == 4'd0);
    w_upper_zero[2] = w_upper_zero[3] && (r_snap_digits[11:8] == 4'd0);
    w_upper_zero[1] = w_upper_zero[2] && (r_snap_digits[7:4] == 4'd0);
    w_blank         = lz_en && (r_idx != 2'd0) && w_upper_zero[r_idx];
  end

  // BCD to active-low {g,f,e,d,c,b,a}; non-BCD values show a dash.
  always_comb begin
    w_seg_code = 7'b0111111;
    case (w_digit)
      4'd0: w_seg_code = 7'b1000000;
      4'd1: w_seg_code = 7'b1111001;
      4'd2: w_seg_code = 7'b0100100;
      4'd3: w_seg_code = 7'b0110000;
      4'd4: w_seg_code = 7'b0011001;
      4'd5: w_seg_code = 7'b0010010;
      4'd6: w_seg_code = 7'b0000010;
      4'd7: w_seg_code = 7'b1111000;
      4'd8: w_seg_code = 7'b0000000;
      4'd9: w_seg_code = 7'b0010000;
      default: w_seg_code = 7'b0111111;
    endcase
  end

  // Output drive: dark in DEAD or when disabled; a blanked digit keeps its anode and dp.
  always_comb begin
    an  = 4'b1111;
    seg = 7'b1111111;
    dp  = 1'b1;
    if (r_state == ST_ON && enable) begin
      an         = 4'b1111;
      an[r_idx]  = 1'b0;
      seg        = w_blank ? 7'b1111111 : w_seg_code;
      dp         = ~r_snap_dp[r_idx];
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver (DIV=4, DEAD=2) with a frame-position model checked every cycle.
module tb_seg_scan_driver;

  localparam int DIV  = 4;
  localparam int DEAD = 2;
  localparam int SLOT = DIV + DEAD;
  localparam int P    = 4 * SLOT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] digits = 16'h1234;
  logic [3:0]  dp_mask = 4'b0000;
  logic        lz_en = 1'b0;
  logic        enable = 1'b1;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int vec = 0;
  int err = 0;

  // Model state: rising edges since reset release and the frame snapshot.
  int          m_k = 0;
  logic [15:0] m_snap = '0;
  logic [3:0]  m_dpm = '0;

  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic        e_fd;

  seg_scan_driver #(.DIV(DIV), .DEAD(DEAD)) dut (
    .clk(clk), .rst(rst), .digits(digits), .dp_mask(dp_mask),
    .lz_en(lz_en), .enable(enable), .an(an), .seg(seg), .dp(dp),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // Model timeline: frame boundaries fall every P edges starting at edge DEAD.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_k    = 0;
      m_snap = '0;
      m_dpm  = '0;
    end else begin
      m_k = m_k + 1;
      if (m_k >= DEAD && ((m_k - DEAD) % P) == 0) begin
        m_snap = digits;
        m_dpm  = dp_mask;
      end
    end
  end

  // Per-cycle compare against the model's view of frame position.
  always @(posedge clk) begin
    int q, d, r;
    bit blank;
    #2;
    e_an = 4'b1111; e_seg = 7'b1111111; e_dp = 1'b1; e_fd = 1'b0;
    if (!rst && m_k >= DEAD) begin
      q = (m_k - DEAD) % P;
      d = q / SLOT;
      r = q % SLOT;
      e_fd = (q == 0);
      if (r < DIV && enable) begin
        blank = 1'b0;
        if (lz_en && d > 0) begin
          blank = 1'b1;
          for (int j = d; j < 4; j++)
            if (m_snap[j*4 +: 4] != 4'd0) blank = 1'b0;
        end
        e_an    = 4'b1111;
        e_an[d] = 1'b0;
        e_seg   = blank ? 7'b1111111 : seg_of(m_snap[d*4 +: 4]);
        e_dp    = ~m_dpm[d];
      end
    end
    vec++;
    if (an !== e_an || seg !== e_seg || dp !== e_dp || frame_done !== e_fd) begin
      err++;
      $display("FAIL scan k=%0d: got an=%b seg=%b dp=%b fd=%b, want an=%b seg=%b dp=%b fd=%b",
               m_k, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
    end
  end

  task automatic lit(input string nm, input logic [3:0] a, input logic [6:0] s,
                     input logic d, input logic f);
    vec++;
    if (an !== a || seg !== s || dp !== d || frame_done !== f) begin
      err++;
      $display("FAIL %s: got an=%b seg=%b dp=%b fd=%b, want an=%b seg=%b dp=%b fd=%b",
               nm, an, seg, dp, frame_done, a, s, d, f);
    end
  endtask

  // Advance to 3 time units after the edge that brings the model to edge count e.
  task automatic goto(input int e);
    int n = 0;
    while (m_k != e && n < 2000) begin
      @(posedge clk);
      #3;
      n++;
    end
    if (m_k != e) begin
      vec++;
      err++;
      $display("FAIL goto: reached k=%0d, want k=%0d", m_k, e);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #3;
    lit("in_reset", 4'b1111, 7'b1111111, 1'b1, 1'b0);
    rst = 1'b0;

    goto(1);  lit("pre_first", 4'b1111, 7'b1111111, 1'b1, 1'b0);
    goto(2);  lit("first_d0",  4'b1110, 7'b0011001, 1'b1, 1'b1);
    goto(3);  lit("d0_hold",   4'b1110, 7'b0011001, 1'b1, 1'b0);
    goto(6);  lit("dead0",     4'b1111, 7'b1111111, 1'b1, 1'b0);
    goto(8);  lit("d1_3",      4'b1101, 7'b0110000, 1'b1, 1'b0);
    digits = 16'h9999;
    goto(14); lit("d2_2_kept", 4'b1011, 7'b0100100, 1'b1, 1'b0);
    goto(20); lit("d3_1_kept", 4'b0111, 7'b1111001, 1'b1, 1'b0);
    goto(26); lit("frame2_9",  4'b1110, 7'b0010000, 1'b1, 1'b1);
    digits = 16'h0050; lz_en = 1'b1;

    goto(50); lit("lz_d0",     4'b1110, 7'b1000000, 1'b1, 1'b1);
    goto(56); lit("lz_d1_5",   4'b1101, 7'b0010010, 1'b1, 1'b0);
    goto(62); lit("lz_d2_bl",  4'b1011, 7'b1111111, 1'b1, 1'b0);
    goto(68); lit("lz_d3_bl",  4'b0111, 7'b1111111, 1'b1, 1'b0);
    digits = 16'h0000;

    goto(74); lit("zero_d0",   4'b1110, 7'b1000000, 1'b1, 1'b1);
    goto(80); lit("zero_d1",   4'b1101, 7'b1111111, 1'b1, 1'b0);
    digits = 16'h00A0; dp_mask = 4'b0100;

    goto(98);  lit("a0_d0",    4'b1110, 7'b1000000, 1'b1, 1'b1);
    goto(104); lit("a0_dash",  4'b1101, 7'b0111111, 1'b1, 1'b0);
    goto(110); lit("a0_d2dp",  4'b1011, 7'b1111111, 1'b0, 1'b0);
    goto(116); lit("a0_d3",    4'b0111, 7'b1111111, 1'b1, 1'b0);
    enable = 1'b0;

    goto(122); lit("dark_fd",  4'b1111, 7'b1111111, 1'b1, 1'b1);
    goto(125); lit("dark_on",  4'b1111, 7'b1111111, 1'b1, 1'b0);
    goto(146); lit("dark_fd2", 4'b1111, 7'b1111111, 1'b1, 1'b1);
    enable = 1'b1;
    goto(152); lit("reen_d1",  4'b1101, 7'b0111111, 1'b1, 1'b0);
    digits = 16'h1234; lz_en = 1'b0; dp_mask = 4'b0000;

    goto(170); lit("f7_d0",    4'b1110, 7'b0011001, 1'b1, 1'b1);
    goto(183); lit("f7_d2",    4'b1011, 7'b0100100, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    lit("rst_async", 4'b1111, 7'b1111111, 1'b1, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #3;
    end
    rst = 1'b0;
    goto(1);  lit("rr_pre",    4'b1111, 7'b1111111, 1'b1, 1'b0);
    goto(2);  lit("rr_first",  4'b1110, 7'b0011001, 1'b1, 1'b1);
    goto(8);  lit("rr_d1",     4'b1101, 7'b0110000, 1'b1, 1'b0);
    goto(30);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter: DIV, default 1000, ON-time in clk cycles per digit (legal range 2..65535).
REQ-002 Parameter: DEAD, default 2, all-anodes-off cycles between digits (legal range 1..255).
REQ-003 Port: clk  input  1  single system clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset; asynchronous, active-high.
REQ-005 Port: digits  input  16  four BCD digits; [3:0] = digit 0 (least significant), [15:12] = digit 3.
REQ-006 Port: dp_mask  input  4  decimal-point request per digit, bit i = digit i, 1 = lit.
REQ-007 Port: lz_en  input  1  1 = leading-zero suppression on.
REQ-008 Port: enable  input  1  0 = display dark; the scan sequencer keeps running.
REQ-009 Port: an  output  4  anode selects, active-low, bit i = digit i.
REQ-010 Port: seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-011 Port: dp  output  1  decimal point, active-low.
REQ-012 Port: frame_done  output  1  one-cycle pulse when a new frame snapshot loads.

Function
REQ-013 The block SHALL use a two-state sequencer, ON and DEAD, with a 2-bit digit index idx, an ON counter (0..DIV-1) and a DEAD counter (0..DEAD-1).
REQ-014 In ON, the ON counter SHALL increment each cycle; at DIV-1 it SHALL clear and the state SHALL go to DEAD.
REQ-015 In DEAD, the DEAD counter SHALL increment each cycle; at DEAD-1 it SHALL clear, idx SHALL advance modulo 4 (3 wraps to 0), and the state SHALL go to ON.
REQ-016 On every DEAD-to-ON transition with new idx = 0, digits and dp_mask SHALL load into snapshot registers, and frame_done SHALL be 1 for exactly the following cycle.
REQ-017 Displayed values and dp SHALL come only from the snapshot; input changes mid-frame SHALL NOT affect the current frame.
REQ-018 A frame SHALL last exactly 4*(DIV+DEAD) cycles.
REQ-019 Outputs SHALL be decoded only from registered state (state, idx, snapshot) and the enable/lz_en inputs; digits and dp_mask SHALL have no combinational path to any output.
REQ-020 In ON with enable=1, an SHALL have only bit idx low; in DEAD or with enable=0, an SHALL be 4'b1111, seg 7'b1111111 and dp 1.
REQ-021 seg encoding (active-low) for BCD values: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-022 For snapshot values 10..15, seg SHALL show a dash, 0111111, and the value SHALL count as nonzero for suppression.
REQ-023 With lz_en=1, digit i (i = 3, 2, 1) SHALL be blanked (seg 1111111, anode still driven) when snapshot digits 3..i are all zero.
REQ-024 Digit 0 SHALL never be blanked; all-zero input SHALL display "0".
REQ-025 During ON with enable=1, dp SHALL be the inverse of snapshot dp_mask[idx], and a blanked digit SHALL still show its dp.
REQ-026 The enable input SHALL NOT alter counters, idx, snapshot or frame_done timing.

Reset
REQ-027 While rst=1, an SHALL be 1111, seg 1111111, dp 1 and frame_done 0, immediately and without waiting for a clock edge.
REQ-028 Reset SHALL set state=DEAD, idx=3, both counters 0 and snapshots 0.
REQ-029 After reset release, the first snapshot load and frame_done SHALL occur on the DEAD-th rising edge.
REQ-030 Reset asserted mid-frame SHALL abort the scan and restart per REQ-028/029; no partial digit SHALL be shown after release.

Verification (DIV=4, DEAD=2)
REQ-031 Reset release, digits=16'h1234, dp_mask=0, lz_en=0, enable=1 -> frame_done at edge 2; an=1110 with seg=0011001 ("4") for 4 cycles; then an=1111 for 2 cycles; then an=1101 "3", 1011 "2", 0111 "1"; next frame_done 24 cycles after the first.
REQ-032 digits=16'h0050, lz_en=1 -> digit3 and digit2 blanked with anodes driven, digit1 "5", digit0 "0"; digits=0 -> only digit0 shows 1000000.
REQ-033 digits changed from 16'h1234 to 16'h9999 while idx=1 -> remainder of the frame shows 3, 2, 1; next frame shows 9999; frame_done aligns with the switch.
REQ-034 digits=16'h00A0, lz_en=1, dp_mask=4'b0100 -> digit1 dash 0111111, digit2 blanked with dp=0, digit3 blanked with dp=1.
REQ-035 enable=0 for a full frame -> an=1111 throughout, frame_done still pulses every 24 cycles; rst pulse during ON of idx2 -> outputs dark at once, then REQ-029 timing.
